uart_apb_sequencer: RTL and testbench



---
 rtl/uart_seq_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/uart_apb_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART APB sequencer: apb_uart register map,
// CTRL/STATUS bit positions, init values and the sequencer state encoding.
// The RX echo states exist only when UART_SEQ_RX_ECHO_EN is defined.
package uart_seq_pkg;

    // apb_uart word addresses
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0001;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_0002;
    localparam logic [31:0] ADDR_RXDATA = 32'h0000_0003;

    // CTRL bit positions
    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_RX_EN  = 1;
    localparam int CTRL_TX_RST = 2;
    localparam int CTRL_RX_RST = 3;

    // STATUS bit positions
    localparam int STATUS_RX_DONE = 0;
    localparam int STATUS_TX_BUSY = 1;

    // Init sequence: hold both paths in reset, then enable both paths
    localparam logic [31:0] CTRL_RESET_VAL  = (32'h1 << CTRL_TX_RST) | (32'h1 << CTRL_RX_RST);
    localparam logic [31:0] CTRL_ENABLE_VAL = (32'h1 << CTRL_TX_EN)  | (32'h1 << CTRL_RX_EN);

    typedef enum logic [2:0] {
        ST_INIT_RST = 3'd0,
        ST_INIT_EN  = 3'd1,
        ST_IDLE     = 3'd2,
        ST_WR_TX    = 3'd3,
        ST_POLL_TX  = 3'd4,
`ifdef UART_SEQ_RX_ECHO_EN
        ST_DONE     = 3'd5,
        ST_POLL_RX  = 3'd6,
        ST_RD_RX    = 3'd7
`else
        ST_DONE     = 3'd5
`endif
    } seq_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the
// pointer, and moves the pointer just past the winner when told to advance.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id
);

    logic [ID_W-1:0] ptr;
    logic            found;
    int              idx;

    // Search requests starting from the pointer, wrapping around once
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

    // Pointer moves to winner+1 only when a grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
        end
    end

endmodule

// File: rtl/uart_apb_sequencer.sv
// APB master that initialises one apb_uart and shares its TX path between
// N_REQ byte requesters, served round-robin.
// Optional feature macro: UART_SEQ_RX_ECHO_EN -- after each byte, wait for
// the loopback RX byte and return it on done_rxdata.
module uart_apb_sequencer
    import uart_seq_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATAWIDTH  = 8,
    parameter int POLL_LIMIT = 4096
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    output logic                           m_psel,
    output logic                           m_penable,
    output logic                           m_pwrite,
    output logic [31:0]                    m_paddr,
    output logic [31:0]                    m_pwdata,
    input  logic [31:0]                    m_prdata,
    input  logic                           m_pready,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*DATAWIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           done_valid,
    output logic [$clog2(N_REQ)-1:0]       done_id,
    output logic                           done_err,
    output logic [DATAWIDTH-1:0]           done_rxdata,
    output logic                           busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(POLL_LIMIT);

    seq_state_e            state;
    logic [DATAWIDTH-1:0]  byte_q;
    logic [ID_W-1:0]       id_q;
    logic                  err_q;
    logic                  busy_q;
    logic [CNT_W-1:0]      poll_cnt;

    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       grant_id;
    logic [DATAWIDTH-1:0]  grant_byte;
    logic                  arb_advance;

    logic [31:0]           xfer_addr;
    logic [31:0]           xfer_wdata;
    logic                  xfer_write;
    logic                  xfer_active;
    logic                  xfer_done;
    logic                  poll_expired;
    logic                  unused_prdata;

    assign arb_advance = (state == ST_IDLE);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .req     (req_valid),
        .advance (arb_advance),
        .grant   (grant),
        .id      (grant_id)
    );

    // Pick out the winning requester's byte from the packed bus
    always_comb begin
        grant_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_byte = req_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // What each transfer state puts on the bus when it starts its SETUP phase
    always_comb begin
        xfer_addr   = ADDR_CTRL;
        xfer_wdata  = '0;
        xfer_write  = 1'b0;
        xfer_active = 1'b1;
        case (state)
            ST_INIT_RST: begin
                xfer_wdata = CTRL_RESET_VAL;
                xfer_write = 1'b1;
            end
            ST_INIT_EN: begin
                xfer_wdata = CTRL_ENABLE_VAL;
                xfer_write = 1'b1;
            end
            ST_WR_TX: begin
                xfer_addr  = ADDR_TXDATA;
                xfer_wdata = 32'(byte_q);
                xfer_write = 1'b1;
            end
            ST_POLL_TX: xfer_addr = ADDR_STATUS;
`ifdef UART_SEQ_RX_ECHO_EN
            ST_POLL_RX: xfer_addr = ADDR_STATUS;
            ST_RD_RX:   xfer_addr = ADDR_RXDATA;
`endif
            default:    xfer_active = 1'b0;
        endcase
    end

    assign xfer_done    = m_psel && m_penable && m_pready;
    assign poll_expired = (poll_cnt == CNT_W'(POLL_LIMIT - 1));
    assign unused_prdata = ^m_prdata;

    assign req_ready  = (state == ST_IDLE) ? grant : '0;
    assign done_valid = (state == ST_DONE);
    assign done_id    = done_valid ? id_q : '0;
    assign done_err   = done_valid && err_q;
    assign busy       = busy_q;

`ifdef UART_SEQ_RX_ECHO_EN
    logic [DATAWIDTH-1:0] rx_q;
    assign done_rxdata = done_valid ? rx_q : '0;
`else
    assign done_rxdata = '0;
`endif

    // Sequencer FSM with the APB SETUP/ACCESS/idle phasing folded in:
    // psel rises one cycle after entering a transfer state, so every
    // transfer is preceded by at least one idle bus cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_INIT_RST;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            byte_q    <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            poll_cnt  <= '0;
`ifdef UART_SEQ_RX_ECHO_EN
            rx_q      <= '0;
`endif
        end else begin
            if (xfer_active) begin
                if (!m_psel) begin
                    m_psel   <= 1'b1;
                    m_paddr  <= xfer_addr;
                    m_pwdata <= xfer_wdata;
                    m_pwrite <= xfer_write;
                end else if (!m_penable) begin
                    m_penable <= 1'b1;
                end else if (m_pready) begin
                    m_psel    <= 1'b0;
                    m_penable <= 1'b0;
                end
            end

            case (state)
                ST_INIT_RST: begin
                    busy_q <= 1'b1;
                    if (xfer_done) state <= ST_INIT_EN;
                end
                ST_INIT_EN: begin
                    if (xfer_done) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (|req_valid) begin
                        byte_q <= grant_byte;
                        id_q   <= grant_id;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
`ifdef UART_SEQ_RX_ECHO_EN
                        rx_q   <= '0;
`endif
                        state  <= ST_WR_TX;
                    end
                end
                ST_WR_TX: begin
                    if (xfer_done) begin
                        poll_cnt <= '0;
                        state    <= ST_POLL_TX;
                    end
                end
                ST_POLL_TX: begin
                    if (xfer_done) begin
                        if (!m_prdata[STATUS_TX_BUSY]) begin
`ifdef UART_SEQ_RX_ECHO_EN
                            poll_cnt <= '0;
                            state    <= ST_POLL_RX;
`else
                            state    <= ST_DONE;
`endif
                        end else if (poll_expired) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            poll_cnt <= poll_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef UART_SEQ_RX_ECHO_EN
                ST_POLL_RX: begin
                    if (xfer_done) begin
                        if (m_prdata[STATUS_RX_DONE]) begin
                            state <= ST_RD_RX;
                        end else if (poll_expired) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            poll_cnt <= poll_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RD_RX: begin
                    if (xfer_done) begin
                        rx_q  <= m_prdata[DATAWIDTH-1:0];
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (err_q) begin
                        state <= ST_INIT_RST;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= ST_INIT_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Scoreboard bench for uart_apb_sequencer with a behavioural apb_uart stub
// (programmable pready stall, stuck tx_busy, loopback RX).
module tb_uart_apb_sequencer;

    localparam int N_REQ      = 4;
    localparam int DW         = 8;
    localparam int POLL_LIMIT = 16;

    typedef struct packed {
        logic       err;
        logic [1:0] id;
        logic [7:0] data;
    } exp_done_t;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b1;
    logic              m_psel, m_penable, m_pwrite;
    logic [31:0]       m_paddr, m_pwdata;
    logic [31:0]       m_prdata = '0;
    logic              m_pready = 1'b0;
    logic [N_REQ-1:0]  req_valid = '0;
    logic [N_REQ*DW-1:0] req_data = '0;
    logic [N_REQ-1:0]  req_ready;
    logic              done_valid;
    logic [1:0]        done_id;
    logic              done_err;
    logic [DW-1:0]     done_rxdata;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Stub slave state
    int          stallCycles = 0;
    int          stallLeft = 0;
    logic        stuckBusy = 1'b0;
    int          txBusyLeft = 0;
    logic [7:0]  lastTx = '0;
    logic        rxValid = 1'b0;
    int          statusReads = 0;
    int          accessCycles = 0;
    int          lastAccessCycles = 0;
    logic [31:0] setupAddr = '0, setupData = '0;
    logic        setupWrite = 1'b0;
    logic        prevDone = 1'b0;
    logic        expectAccess = 1'b0;
    logic        isBusy;

    // Scoreboard
    logic [31:0] ctrlLog[$];
    int          expGrant[$];
    logic [7:0]  expTx[$];
    exp_done_t   expDone[$];
    int          modelPtr = 0;
    int          doneSeen = 0;
    int          cycle = 0;
    int          grantCycle = 0;
    logic [N_REQ-1:0] dropMask = '0;

    uart_apb_sequencer #(
        .N_REQ      (N_REQ),
        .DATAWIDTH  (DW),
        .POLL_LIMIT (POLL_LIMIT)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .m_psel      (m_psel),
        .m_penable   (m_penable),
        .m_pwrite    (m_pwrite),
        .m_paddr     (m_paddr),
        .m_pwdata    (m_pwdata),
        .m_prdata    (m_prdata),
        .m_pready    (m_pready),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .done_err    (done_err),
        .done_rxdata (done_rxdata),
        .busy        (busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rrPick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    // Push expectations in model round-robin order, then raise the valids
    task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] bytes, input logic expErr);
        logic [3:0] pending;
        int         pick;
        exp_done_t  e;
        pending = mask;
        while (pending != 0) begin
            pick = rrPick(pending, modelPtr);
            expGrant.push_back(pick);
            expTx.push_back(bytes[pick*8 +: 8]);
            e.err  = expErr;
            e.id   = 2'(pick);
            e.data = bytes[pick*8 +: 8];
            expDone.push_back(e);
            modelPtr = (pick + 1) % N_REQ;
            pending[pick] = 1'b0;
        end
        @(posedge PCLK);
        #2;
        for (int i = 0; i < N_REQ; i++) begin
            if (mask[i]) req_data[i*8 +: 8] = bytes[i*8 +: 8];
        end
        req_valid = req_valid | mask;
    endtask

    task automatic waitDone(input int target, input int budget);
        for (int i = 0; i < budget && doneSeen < target; i++) @(posedge PCLK);
        if (doneSeen < target) checkOutput("done_wait_timeout", doneSeen, target);
    endtask

    task automatic waitCtrl(input int target, input int budget);
        for (int i = 0; i < budget && ctrlLog.size() < target; i++) @(posedge PCLK);
        if (ctrlLog.size() < target) checkOutput("ctrl_wait_timeout", ctrlLog.size(), target);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_apb_ctl"}, {m_psel, m_penable, m_pwrite}, 0);
        checkOutput({tag, "_paddr"}, m_paddr, 0);
        checkOutput({tag, "_pwdata"}, m_pwdata, 0);
        checkOutput({tag, "_req_ready"}, req_ready, 0);
        checkOutput({tag, "_done"}, {done_valid, done_id, done_err, done_rxdata}, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // Requesters drop their valid right after the edge that accepted them
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            if (dropMask != 0) begin
                req_valid = req_valid & ~dropMask;
                dropMask  = '0;
            end
        end
    end

    // Stub apb_uart slave plus output monitors, evaluated mid-cycle
    initial begin
        forever begin
            @(negedge PCLK);
            cycle++;
            if (!PRESETn) begin
                m_pready     = 1'b0;
                stallLeft    = 0;
                txBusyLeft   = 0;
                rxValid      = 1'b0;
                prevDone     = 1'b0;
                expectAccess = 1'b0;
            end else begin
                if (prevDone) checkOutput("apb_idle_gap", m_psel, 0);
                if (expectAccess) checkOutput("psel_held", {m_psel, m_penable}, 2'b11);
                prevDone     = 1'b0;
                expectAccess = 1'b0;
                if (m_psel && !m_penable) begin
                    setupAddr    = m_paddr;
                    setupData    = m_pwdata;
                    setupWrite   = m_pwrite;
                    stallLeft    = stallCycles;
                    accessCycles = 0;
                    m_pready     = 1'b0;
                end else if (m_psel && m_penable) begin
                    accessCycles++;
                    checkOutput("paddr_stable", m_paddr, setupAddr);
                    checkOutput("pwdata_stable", m_pwdata, setupData);
                    checkOutput("pwrite_stable", m_pwrite, setupWrite);
                    if (stallLeft > 0) begin
                        stallLeft--;
                        m_pready     = 1'b0;
                        expectAccess = 1'b1;
                    end else begin
                        m_pready         = 1'b1;
                        prevDone         = 1'b1;
                        lastAccessCycles = accessCycles;
                        if (m_pwrite) begin
                            if (m_paddr == 32'h0) ctrlLog.push_back(m_pwdata);
                            else if (m_paddr == 32'h2) begin
                                if (expTx.size() == 0) checkOutput("tx_unexpected", m_pwdata, 32'hFFFF_FFFF);
                                else checkOutput("tx_byte", m_pwdata, 32'(expTx.pop_front()));
                                lastTx      = m_pwdata[7:0];
                                txBusyLeft  = 2;
                                rxValid     = 1'b0;
                                statusReads = 0;
                            end
                        end else begin
                            if (m_paddr == 32'h1) begin
                                statusReads++;
                                isBusy   = stuckBusy || (txBusyLeft > 0);
                                m_prdata = {30'd0, isBusy, rxValid};
                                if (txBusyLeft > 0) txBusyLeft--;
                                if (!isBusy) rxValid = 1'b1;
                            end else if (m_paddr == 32'h3) begin
                                m_prdata = {24'd0, lastTx};
                                rxValid  = 1'b0;
                            end else begin
                                m_prdata = '0;
                            end
                        end
                    end
                end else begin
                    m_pready = 1'b0;
                end

                if (req_ready != 0) begin
                    checkOutput("req_ready_onehot", $countones(req_ready), 1);
                    for (int i = 0; i < N_REQ; i++) begin
                        if (req_ready[i]) begin
                            if (expGrant.size() == 0) checkOutput("grant_unexpected", i, 99);
                            else checkOutput("grant_id", i, expGrant.pop_front());
                        end
                    end
                    grantCycle = cycle;
                    dropMask   = req_ready;
                end

                if (done_valid) begin
                    exp_done_t e;
                    doneSeen++;
                    checkOutput("latency_min", (cycle - grantCycle) >= 7, 1);
                    if (expDone.size() == 0) begin
                        checkOutput("done_unexpected", done_valid, 0);
                    end else begin
                        e = expDone.pop_front();
                        checkOutput("done_id", done_id, e.id);
                        checkOutput("done_err", done_err, e.err);
`ifdef UART_SEQ_RX_ECHO_EN
                        if (!e.err) checkOutput("done_rxdata", done_rxdata, e.data);
`else
                        checkOutput("done_rxdata", done_rxdata, 0);
`endif
                    end
                end
            end
        end
    end

    initial begin
        int  base;
        logic found;

        // Reset state
        #1 PRESETn = 1'b0;
        #2 checkResetOutputs("reset");
        repeat (3) @(posedge PCLK);
        #3 PRESETn = 1'b1;

        // Init sequence after reset release
        waitCtrl(2, 50);
        checkOutput("init_ctrl0", ctrlLog[0], 32'h0C);
        checkOutput("init_ctrl1", ctrlLog[1], 32'h03);
        repeat (2) @(posedge PCLK);
        #1 checkOutput("idle_busy", busy, 0);

        // All four requesters at once, then two re-requests
        base = doneSeen;
        applyStimulus(4'hF, 32'h44332211, 1'b0);
        waitDone(base + 4, 400);
        base = doneSeen;
        applyStimulus(4'h3, 32'h0000B2B1, 1'b0);
        waitDone(base + 2, 200);

        // Single requester 2 with 0xA5
        base = doneSeen;
        applyStimulus(4'h4, 32'h00A50000, 1'b0);
        waitDone(base + 1, 100);

        // Slave stalls pready for 5 ACCESS cycles
        stallCycles = 5;
        base = doneSeen;
        applyStimulus(4'h1, 32'h0000003C, 1'b0);
        waitDone(base + 1, 300);
        checkOutput("stall_access_cycles", lastAccessCycles, 6);
        stallCycles = 0;

        // tx_busy stuck: timeout after exactly POLL_LIMIT reads, then re-init
        stuckBusy = 1'b1;
        base = ctrlLog.size();
        applyStimulus(4'h2, 32'h00005A00, 1'b1);
        waitDone(doneSeen + 1, 500);
        checkOutput("timeout_status_reads", statusReads, POLL_LIMIT);
        stuckBusy = 1'b0;
        waitCtrl(base + 2, 50);
        checkOutput("reinit_ctrl0", ctrlLog[base], 32'h0C);
        checkOutput("reinit_ctrl1", ctrlLog[base + 1], 32'h03);
        repeat (2) @(posedge PCLK);
        #1 checkOutput("reinit_busy", busy, 0);

        // Reset pulsed while polling STATUS
        applyStimulus(4'h8, 32'h77000000, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge PCLK);
            if (m_psel && !m_penable && !m_pwrite && m_paddr == 32'h1) found = 1'b1;
        end
        checkOutput("poll_seen", found, 1);
        #2 PRESETn = 1'b0;
        #1 checkResetOutputs("midreset");
        expDone.delete();
        modelPtr = 0;
        base = ctrlLog.size();
        repeat (2) @(posedge PCLK);
        #3 PRESETn = 1'b1;
        waitCtrl(base + 2, 50);
        checkOutput("rst_ctrl0", ctrlLog[base], 32'h0C);
        checkOutput("rst_ctrl1", ctrlLog[base + 1], 32'h03);

        // Arbiter restarted from pointer 0 after reset
        base = doneSeen;
        applyStimulus(4'hA, 32'h99008800, 1'b0);
        waitDone(base + 2, 200);

        repeat (3) @(posedge PCLK);
        checkOutput("exp_grant_empty", expGrant.size(), 0);
        checkOutput("exp_tx_empty", expTx.size(), 0);
        checkOutput("exp_done_empty", expDone.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
